// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes, functs,
// memory-depth defaults and the ALU operation enum.
package cpu_pkg;

    localparam int IMEM_WORDS_DEF = 1024;
    localparam int DMEM_WORDS_DEF = 256;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_register_file.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired.
// With CPU_DEBUG_EN defined, $1 is also exposed on reg1.
module register_file
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
`ifdef CPU_DEBUG_EN
    ,
    output logic [31:0] reg1
`endif
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-edge value, so a same-edge write is not forwarded.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

`ifdef CPU_DEBUG_EN
    assign reg1 = regs[1];
`endif

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core retiring one instruction per rising edge.
// Optional CPU_DEBUG_EN adds output debug_reg1 mirroring register $1.
module cpu
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int DMEM_WORDS = DMEM_WORDS_DEF
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [32*IMEM_WORDS-1:0] instruction_stream
`ifdef CPU_DEBUG_EN
    ,
    output logic [31:0]             debug_reg1
`endif
);

    localparam int PC_W  = $clog2(IMEM_WORDS);
    localparam int DM_AW = $clog2(DMEM_WORDS);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus1;
    logic [31:0]     instr;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    alu_op_e     alu_op;
    logic        use_imm;
    logic [31:0] imm_ext;
    logic        reg_we;
    logic [4:0]  wa;
    logic        mem_we;
    logic        mem_rd;
    logic        branch;
    logic        jump;

    logic signed [31:0] alu_a;
    logic signed [31:0] alu_b;
    logic [31:0]        alu_result;
    logic [31:0]        wd;

    logic [31:0]      dmem [DMEM_WORDS];
    logic [DM_AW-1:0] dm_idx;

    assign instr  = instruction_stream[{pc, 5'b00000} +: 32];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    register_file rf (
        .clk  (clk),
        .rst  (rst),
        .ra1  (rs),
        .ra2  (rt),
        .rd1  (rs_val),
        .rd2  (rt_val),
        .we   (reg_we),
        .wa   (wa),
        .wd   (wd)
`ifdef CPU_DEBUG_EN
        ,
        .reg1 (debug_reg1)
`endif
    );

    // Unknown opcodes and functs fall through with every write enable low.
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        imm_ext = sext16(imm);
        reg_we  = 1'b0;
        wa      = rd;
        mem_we  = 1'b0;
        mem_rd  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin alu_op = ALU_ADD; reg_we = 1'b1; end
                    FN_SUB:  begin alu_op = ALU_SUB; reg_we = 1'b1; end
                    FN_AND:  begin alu_op = ALU_AND; reg_we = 1'b1; end
                    FN_OR:   begin alu_op = ALU_OR;  reg_we = 1'b1; end
                    FN_SLT:  begin alu_op = ALU_SLT; reg_we = 1'b1; end
                    FN_SLL:  begin alu_op = ALU_SLL; reg_we = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin use_imm = 1'b1; reg_we = 1'b1; wa = rt; end
            OP_ANDI: begin
                alu_op = ALU_AND; use_imm = 1'b1; imm_ext = {16'd0, imm};
                reg_we = 1'b1; wa = rt;
            end
            OP_ORI: begin
                alu_op = ALU_OR; use_imm = 1'b1; imm_ext = {16'd0, imm};
                reg_we = 1'b1; wa = rt;
            end
            OP_SLTI: begin alu_op = ALU_SLT; use_imm = 1'b1; reg_we = 1'b1; wa = rt; end
            OP_LUI:  begin alu_op = ALU_LUI; reg_we = 1'b1; wa = rt; end
            OP_LW:   begin use_imm = 1'b1; reg_we = 1'b1; wa = rt; mem_rd = 1'b1; end
            OP_SW:   begin use_imm = 1'b1; mem_we = 1'b1; end
            OP_BEQ:  branch = 1'b1;
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign alu_a = signed'(rs_val);
    assign alu_b = use_imm ? signed'(imm_ext) : signed'(rt_val);

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_SLT: alu_result = {31'd0, (alu_a < alu_b)};
            ALU_SLL: alu_result = rt_val << shamt;
            ALU_LUI: alu_result = {imm, 16'd0};
            default: alu_result = '0;
        endcase
    end

    // Byte address from the ALU; the low two bits select nothing.
    assign dm_idx = alu_result[DM_AW+1:2];
    assign wd     = mem_rd ? dmem[dm_idx] : alu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= '0;
            end
        end else if (mem_we) begin
            dmem[dm_idx] <= rt_val;
        end
    end

    assign pc_plus1 = pc + PC_W'(1);

    always_comb begin
        pc_next = pc_plus1;
        if (jump) begin
            pc_next = instr[PC_W-1:0];
        end else if (branch && (rs_val == rt_val)) begin
            pc_next = pc_plus1 + imm_ext[PC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus random programs checked
// every cycle against an instruction-level reference model.
module tb_cpu;

    logic           clk;
    logic           rst;
    logic [32767:0] prog;
`ifdef CPU_DEBUG_EN
    logic [31:0]    debug_reg1;
`endif

    int vectors;
    int miscompares;

    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [256];
    int          m_pc;

    cpu dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_stream (prog)
`ifdef CPU_DEBUG_EN
        ,
        .debug_reg1         (debug_reg1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'b000000, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op[5:0], rs[4:0], rt[4:0], imm};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'b000010, 16'd0, target[9:0]};
    endfunction

    task automatic set_word(input int i, input logic [31:0] w);
        prog[32*i +: 32] = w;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction-level reference: one call = one architectural step.
    task automatic model_step();
        logic [31:0] w, a, b, se, ze, res;
        int dst, npc, idx;
        logic [5:0] op, fn;
        if (rst) begin
            m_pc = 0;
            foreach (m_regs[i]) m_regs[i] = '0;
            foreach (m_dmem[i]) m_dmem[i] = '0;
            return;
        end
        w   = prog[32*m_pc +: 32];
        op  = w[31:26];
        fn  = w[5:0];
        a   = m_regs[w[25:21]];
        b   = m_regs[w[20:16]];
        se  = {{16{w[15]}}, w[15:0]};
        ze  = {16'd0, w[15:0]};
        idx = int'(((a + se) >> 2) & 32'hFF);
        npc = (m_pc + 1) % 1024;
        dst = -1;
        res = '0;
        case (op)
            6'd0: begin
                dst = int'(w[15:11]);
                case (fn)
                    6'd32: res = a + b;
                    6'd34: res = a - b;
                    6'd36: res = a & b;
                    6'd37: res = a | b;
                    6'd42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'd0:  res = b << w[10:6];
                    default: dst = -1;
                endcase
            end
            6'd8:  begin dst = int'(w[20:16]); res = a + se; end
            6'd12: begin dst = int'(w[20:16]); res = a & ze; end
            6'd13: begin dst = int'(w[20:16]); res = a | ze; end
            6'd10: begin dst = int'(w[20:16]); res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'd15: begin dst = int'(w[20:16]); res = {w[15:0], 16'd0}; end
            6'd35: begin dst = int'(w[20:16]); res = m_dmem[idx]; end
            6'd43: m_dmem[idx] = b;
            6'd4:  if (a == b) npc = (m_pc + 1 + $signed(se)) & 1023;
            6'd2:  npc = int'(w[9:0]);
            default: ;
        endcase
        if (dst > 0) m_regs[dst] = res;
        m_pc = npc;
    endtask

    task automatic tick();
        int bad;
        model_step();
        @(posedge clk);
        #1;
        check("pc", 32'(dut.pc), 32'(m_pc));
        for (int r = 0; r < 32; r++) begin
            check($sformatf("reg%0d", r), dut.rf.regs[r], m_regs[r]);
        end
        bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (bad < 0 && dut.dmem[i] !== m_dmem[i]) bad = i;
        end
        if (bad >= 0) check($sformatf("dmem%0d", bad), dut.dmem[bad], m_dmem[bad]);
        else          check("dmem", 32'd0, 32'd0 + (bad < 0 ? 32'd0 : 32'd1));
`ifdef CPU_DEBUG_EN
        check("debug_reg1", debug_reg1, m_regs[1]);
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        logic [15:0] imm;
        k   = $urandom_range(0, 15);
        rs  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        rt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        imm = 16'($urandom);
        case (k)
            0:  return enc_r(32, rs, rt, rd, 0);
            1:  return enc_r(34, rs, rt, rd, 0);
            2:  return enc_r(36, rs, rt, rd, 0);
            3:  return enc_r(37, rs, rt, rd, 0);
            4:  return enc_r(42, rs, rt, rd, 0);
            5:  return enc_r(0, 0, rt, rd, $urandom_range(0, 31));
            6:  return enc_i(8, rs, rt, imm);
            7:  return enc_i(12, rs, rt, imm);
            8:  return enc_i(13, rs, rt, imm);
            9:  return enc_i(10, rs, rt, imm);
            10: return enc_i(15, 0, rt, imm);
            11: return enc_i(35, rs, rt, imm);
            12: return enc_i(43, rs, rt, imm);
            13: return enc_i(4, rs, rt, 16'($urandom_range(0, 16)) - 16'd8);
            14: return enc_j($urandom_range(0, 1023));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_pc        = 0;
        prog        = '0;
        rst         = 1'b1;

        // Increment sequence, then NOPs through the pc wrap.
        set_word(0, enc_i(8, 0, 1, 16'd1));
        set_word(1, enc_r(32, 1, 1, 1, 0));
        set_word(2, enc_i(8, 0, 1, 16'd7));
        set_word(3, enc_r(32, 1, 1, 1, 0));
        tick();
        check("rst_pc", 32'(dut.pc), 32'd0);
        check("rst_r1", dut.rf.regs[1], 32'd0);
        rst = 1'b0;
        tick(); check("t1_r1_e1", dut.rf.regs[1], 32'd1);
        tick(); check("t1_r1_e2", dut.rf.regs[1], 32'd2);
        tick(); check("t1_r1_e3", dut.rf.regs[1], 32'd7);
        tick(); check("t1_r1_e4", dut.rf.regs[1], 32'd14);
        check("t1_pc", 32'(dut.pc), 32'd4);
        for (int i = 0; i < 1019; i++) tick();
        check("t2_pc_1023", 32'(dut.pc), 32'd1023);
        check("t2_r1", dut.rf.regs[1], 32'd14);
        tick();
        check("t2_wrap", 32'(dut.pc), 32'd0);

        // Arithmetic, memory, branch and jump program.
        prog = '0;
        set_word(0,  enc_i(8, 0, 2, 16'hFFFB));
        set_word(1,  enc_r(42, 2, 0, 3, 0));
        set_word(2,  enc_r(34, 0, 2, 4, 0));
        set_word(3,  enc_i(8, 0, 0, 16'd9));
        set_word(4,  enc_i(8, 0, 5, 16'h1234));
        set_word(5,  enc_i(43, 0, 5, 16'd8));
        set_word(6,  enc_i(35, 0, 6, 16'd8));
        set_word(7,  enc_i(15, 0, 7, 16'hABCD));
        set_word(8,  enc_i(8, 0, 1, 16'd3));
        set_word(9,  enc_i(4, 1, 0, 16'd2));
        set_word(10, enc_i(4, 0, 0, 16'hFFFF));
        set_word(20, enc_i(4, 0, 0, 16'd3));
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); check("t3_r2", dut.rf.regs[2], 32'hFFFF_FFFB);
        tick(); check("t3_slt", dut.rf.regs[3], 32'd1);
        tick(); check("t3_sub", dut.rf.regs[4], 32'd5);
        tick(); check("t3_r0", dut.rf.regs[0], 32'd0);
        tick(); tick(); tick();
        check("t4_lw", dut.rf.regs[6], 32'h0000_1234);
        check("t4_dmem2", dut.dmem[2], 32'h0000_1234);
        tick(); check("t4_lui", dut.rf.regs[7], 32'hABCD_0000);
        tick(); tick();
        check("t5_beq_not_taken", 32'(dut.pc), 32'd10);
        tick(); tick(); tick();
        check("t5_beq_self", 32'(dut.pc), 32'd10);
        set_word(10, enc_j(20));
        tick(); check("t5_j", 32'(dut.pc), 32'd20);
        tick(); check("t5_beq_fwd", 32'(dut.pc), 32'd24);

        // Random programs with occasional reset and live image edits.
        for (int i = 0; i < 1024; i++) set_word(i, rand_instr());
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) set_word($urandom_range(0, 1023), rand_instr());
            tick();
        end

        // Mid-program reset.
        rst = 1'b0;
        set_word(0, enc_i(8, 0, 1, 16'd5));
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1; tick();
        check("t6_pc", 32'(dut.pc), 32'd0);
        check("t6_r1", dut.rf.regs[1], 32'd0);
`ifdef CPU_DEBUG_EN
        check("t6_debug", debug_reg1, 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("t6_r1_after", dut.rf.regs[1], 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
